// File: rtl/led_tick_ctrl.sv
// led_tick_ctrl: step-pulse rate generator plus debounced direction toggle for the LED shift register.
// Optional feature macro: LED_TICK_CTRL_SYNC_EN adds two-flop input synchronizers (latency 2).
// Ports:
//   clock      in   single clock, rising edge
//   i_reset_n  in   asynchronous active-low reset
//   i_enable   in   run switch, 1 = stepping enabled
//   i_sel      in   [1:0] rate select (R0..R3)
//   i_btn      in   raw bouncing push-button, 1 = pressed
//   o_valid    out  registered one-cycle step pulse
//   o_reverse  out  registered direction level, toggles once per debounced press
module led_tick_ctrl #(
   parameter int              NB_COUNTER = 32,
   parameter longint unsigned R0         = 100_000_000,
   parameter longint unsigned R1         = 50_000_000,
   parameter longint unsigned R2         = 25_000_000,
   parameter longint unsigned R3         = 12_500_000,
   parameter int              DEB_CYCLES = 1_000_000
) (
   input  logic       clock,
   input  logic       i_reset_n,
   input  logic       i_enable,
   input  logic [1:0] i_sel,
   input  logic       i_btn,
   output logic       o_valid,
   output logic       o_reverse
);
   localparam int DW = $clog2(DEB_CYCLES) + 1;
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
   logic                  en_s;
   logic [1:0]            sel_s;
   logic                  btn_s;
   logic [NB_COUNTER-1:0] lim;
   logic [NB_COUNTER-1:0] cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   state_t                state_q, state_d;
   logic [DW-1:0]         dcnt_q, dcnt_d;
   logic                  rev_q, rev_d;
   logic                  deb_done;
`ifdef LED_TICK_CTRL_SYNC_EN
   logic [3:0] sync1_q, sync2_q;
   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {i_enable, i_sel, i_btn};
         sync2_q <= sync1_q;
      end
   end
   assign {en_s, sel_s, btn_s} = sync2_q;
`else
   assign {en_s, sel_s, btn_s} = {i_enable, i_sel, i_btn};
`endif
   assign lim = sel_s == 2'd0 ? NB_COUNTER'(R0 - 1) :
                sel_s == 2'd1 ? NB_COUNTER'(R1 - 1) :
                sel_s == 2'd2 ? NB_COUNTER'(R2 - 1) : NB_COUNTER'(R3 - 1);
   // >= rather than == so a switch to a shorter period never wraps past the new limit
   always_comb begin
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      if (en_s) begin
         valid_d = cnt_q >= lim;
         cnt_d   = (cnt_q >= lim) ? '0 : cnt_q + NB_COUNTER'(1);
      end
   end
   assign deb_done = dcnt_q == DW'(DEB_CYCLES - 1);
   always_comb begin
      state_d = state_q;
      rev_d   = rev_q;
      dcnt_d  = dcnt_q + DW'(1);
      case (state_q)
         IDLE:         if (btn_s) state_d = PRESS_WAIT;
         PRESS_WAIT:   if (!btn_s) state_d = IDLE;
                       else if (deb_done) begin
                          state_d = PRESSED;
                          rev_d   = ~rev_q;
                       end
         PRESSED:      if (!btn_s) state_d = RELEASE_WAIT;
         RELEASE_WAIT: if (btn_s) state_d = PRESSED;
                       else if (deb_done) state_d = IDLE;
      endcase
      if (state_d != state_q) dcnt_d = '0;
   end
   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         state_q <= IDLE;
         dcnt_q  <= '0;
         rev_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         rev_q   <= rev_d;
      end
   end
   assign o_valid   = valid_q;
   assign o_reverse = rev_q;
endmodule
